// File: rtl/add32_sched.sv
// Two-requester multi-byte adder that time-shares one external 8-bit adder.
// It adds one byte slice per cycle and spends an extra INC pass on any slice entered with a carry.
module add32_sched #(
  parameter int N_BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [8*N_BYTES-1:0] req0_a,
  input  logic [8*N_BYTES-1:0] req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [8*N_BYTES-1:0] req1_a,
  input  logic [8*N_BYTES-1:0] req1_b,
  output logic [7:0]           add_a,
  output logic [7:0]           add_b,
  input  logic [7:0]           add_sum,
  input  logic                 add_carry,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [8*N_BYTES-1:0] rsp_sum,
  output logic                 rsp_carry,
  output logic                 rsp_id,
  output logic [1:0]           dbg_state_o
);

  localparam int W  = 8 * N_BYTES;
  localparam int IW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    INC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
  logic [IW-1:0]   i_q;
  logic            cin_q;
  logic [7:0]      tmp_q;
  logic            c1_q;
  logic            id_q;
  logic            last_q;
  logic            rsp_valid_q;
  logic            rsp_carry_q;

  logic            last_slice;
  logic            cin_d;
  logic            accept0;
  logic            accept1;

  // Handshakes: a transfer happens on the rising edge where valid and ready are both 1.
  // Requesters keep valid and operands steady until accepted; rsp_* stay steady until rsp_ready.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == IDLE) begin
      req0_ready = req0_valid && (!req1_valid || last_q);
      req1_ready = req1_valid && (!req0_valid || !last_q);
    end
  end

  assign accept0 = req0_valid && req0_ready;
  assign accept1 = req1_valid && req1_ready;

  always_comb begin
    add_a = 8'h00;
    add_b = 8'h00;
    case (state_q)
      ADD: begin
        add_a = a_q[{i_q, 3'b000} +: 8];
        add_b = b_q[{i_q, 3'b000} +: 8];
      end
      INC: begin
        add_a = tmp_q;
        add_b = 8'h01;
      end
      default: ;
    endcase
  end

  assign last_slice = (i_q == IW'(N_BYTES - 1));
  // The INC pass can only carry out when the ADD pass did not, so OR-ing is exact.
  assign cin_d      = (state_q == INC) ? (c1_q | add_carry) : add_carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      i_q         <= '0;
      cin_q       <= 1'b0;
      tmp_q       <= 8'h00;
      c1_q        <= 1'b0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_carry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept0 || accept1) begin
            a_q     <= accept0 ? req0_a : req1_a;
            b_q     <= accept0 ? req0_b : req1_b;
            id_q    <= accept1;
            i_q     <= '0;
            cin_q   <= 1'b0;
            state_q <= ADD;
          end
        end
        ADD, INC: begin
          if (state_q == ADD && cin_q) begin
            tmp_q   <= add_sum;
            c1_q    <= add_carry;
            state_q <= INC;
          end else begin
            sum_q[{i_q, 3'b000} +: 8] <= add_sum;
            cin_q <= cin_d;
            if (last_slice) begin
              i_q         <= '0;
              rsp_valid_q <= 1'b1;
              rsp_carry_q <= cin_d;
              state_q     <= DONE;
            end else begin
              i_q     <= i_q + 1'b1;
              state_q <= ADD;
            end
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            last_q      <= id_q;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_sum     = sum_q;
  assign rsp_carry   = rsp_carry_q;
  assign rsp_id      = id_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_add32_sched.sv
// Directed bench for add32_sched: arbitration, back-pressure, carry-chain latency and mid-transaction reset.
// The external 8-bit adder is modelled here as plain combinational logic.
module tb_add32_sched;

  localparam int W = 32;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INC  = 2'd2;

  logic         clk;
  logic         rst;
  logic         req0_valid, req0_ready;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready;
  logic [W-1:0] req1_a, req1_b;
  logic [7:0]   add_a, add_b, add_sum;
  logic         add_carry;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_carry, rsp_id;
  logic [1:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  add32_sched #(.N_BYTES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sum    (add_sum),
    .add_carry  (add_carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_carry  (rsp_carry),
    .rsp_id     (rsp_id),
    .dbg_state_o(dbg_state)
  );

  assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one request and follow it to completion; entered and left at a negedge with DUT in IDLE.
  task automatic run_txn(input string tag, input logic sel, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_sum,
                         input logic exp_carry, input int exp_lat, input int exp_k,
                         input int exp_b01);
    int cnt;
    int lat;
    int k;
    int b01;
    if (sel) begin
      req1_a = a; req1_b = b; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_valid = 1'b1;
    end
    #1;
    cnt = 0;
    while (!(sel ? req1_ready : req0_ready) && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_accept_wait"}, 64'(cnt < 20), 64'd1);
    @(posedge clk);
    #1;
    if (sel) req1_valid = 1'b0; else req0_valid = 1'b0;
    lat = 0; k = 0; b01 = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (dbg_state == S_INC) k++;
      if (add_b == 8'h01) b01++;
      @(posedge clk);
      lat++;
    end
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, "_latency"},   64'(lat),       64'(exp_lat));
    check({tag, "_inc_passes"}, 64'(k),        64'(exp_k));
    check({tag, "_addb_01"},   64'(b01),       64'(exp_b01));
    check({tag, "_sum"},       64'(rsp_sum),   64'(exp_sum));
    check({tag, "_carry"},     64'(rsp_carry), 64'(exp_carry));
    check({tag, "_id"},        64'(rsp_id),    64'(sel));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_back_idle"}, 64'(dbg_state), 64'(S_IDLE));
    check({tag, "_rsp_drop"},  64'(rsp_valid), 64'd0);
  endtask

  logic [W-1:0] arb_sum [4];
  logic         arb_carry [4];
  logic         arb_id [4];
  logic [W-1:0] held_sum;
  int           cnt;

  initial begin
    arb_id[0] = 1'b0; arb_sum[0] = 32'h3333_3333; arb_carry[0] = 1'b0;
    arb_id[1] = 1'b1; arb_sum[1] = 32'h0000_0000; arb_carry[1] = 1'b1;
    arb_id[2] = 1'b0; arb_sum[2] = 32'h3333_3333; arb_carry[2] = 1'b0;
    arb_id[3] = 1'b1; arb_sum[3] = 32'h0000_0000; arb_carry[3] = 1'b1;

    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_sum",   64'(rsp_sum),   64'd0);
    check("rst_rsp_carry", 64'(rsp_carry), 64'd0);
    check("rst_rsp_id",    64'(rsp_id),    64'd0);
    check("rst_state",     64'(dbg_state), 64'(S_IDLE));
    check("rst_add_ab",    64'({add_a, add_b}), 64'd0);
    rst = 1'b0;

    // Both requesters held valid: round-robin 0,1,0,1; first response back-pressured 3 cycles.
    req0_a = 32'h1111_1111; req0_b = 32'h2222_2222;
    req1_a = 32'h8000_0000; req1_b = 32'h8000_0000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("arb_tie_r0", 64'(req0_ready), 64'd1);
    check("arb_tie_r1", 64'(req1_ready), 64'd0);
    for (int r = 0; r < 4; r++) begin
      cnt = 0;
      while (!rsp_valid && cnt < 30) begin
        @(negedge clk);
        cnt++;
      end
      check("arb_rsp_wait", 64'(rsp_valid), 64'd1);
      check("arb_id",    64'(rsp_id),    64'(arb_id[r]));
      check("arb_sum",   64'(rsp_sum),   64'(arb_sum[r]));
      check("arb_carry", 64'(rsp_carry), 64'(arb_carry[r]));
      held_sum = rsp_sum;
      for (int h = 0; h < ((r == 0) ? 3 : 0); h++) begin
        @(negedge clk);
        check("hold_valid", 64'(rsp_valid), 64'd1);
        check("hold_sum",   64'(rsp_sum),   64'(held_sum));
        check("hold_id",    64'(rsp_id),    64'(arb_id[r]));
        check("hold_carry", 64'(rsp_carry), 64'(arb_carry[r]));
        check("hold_ready", 64'({req0_ready, req1_ready}), 64'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("arb_idle_after_hs", 64'(dbg_state), 64'(S_IDLE));
      check("arb_rsp_drop",      64'(rsp_valid), 64'd0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    run_txn("ff_plus_1",   1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 5, 1, 2);
    run_txn("all_ones",    1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 7, 3, 4);
    run_txn("mixed",       1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3568, 1'b0, 6, 2, 2);

    // Reset during INC: last served was req0, so only the reset makes req0 win the next tie.
    req0_a = 32'hFFFF_FFFF; req0_b = 32'h0000_0001; req0_valid = 1'b1;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    cnt = 0;
    while (dbg_state != S_INC && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("mid_reach_inc", 64'(dbg_state), 64'(S_INC));
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("mid_no_rsp", 64'(rsp_valid), 64'd0);
    end
    req1_a = 32'h0000_0005; req1_b = 32'h0000_0006; req1_valid = 1'b1;
    req0_a = 32'h00FF_00FF; req0_b = 32'h0001_0001; req0_valid = 1'b1;
    #1;
    check("post_rst_tie_r0", 64'(req0_ready), 64'd1);
    check("post_rst_tie_r1", 64'(req1_ready), 64'd0);
    run_txn("post_rst", 1'b0, 32'h00FF_00FF, 32'h0001_0001, 32'h0100_0100, 1'b0, 6, 2, 4);
    req1_valid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
